// File: rtl/power_domain_manager_if.sv
// power_domain_manager_if
//   Groups the controller's configuration, per-domain handshake and status
//   signals into one bundle.
//   master : the power-domain controller. It drives the switch requests and
//            the status outputs.
//   slave  : the environment (functional units, switch fabric, monitors).
//   Signals:
//     idle_thresh      consecutive idle cycles before gating (0 = never gate)
//     domain_idle      per-domain idle indication
//     wake_req         per-domain level wake request
//     pwr_gated_ack    switch status, 1 = fully off
//     pwr_gate_req     1 = request switch off
//     domain_ready     1 only while the domain is ON
//     domain_state     2-bit state code per domain, domain i at [2i+1:2i]
//     active_count     number of domains ON
//     all_gated        every domain OFF
//     ack_timeout_err  sticky per-domain handshake timeout flag
//     efficiency_pct   gated domain-cycle percentage of the last window
//     efficiency_valid one-cycle pulse when efficiency_pct updates
interface power_domain_manager_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8
);
  localparam int CNT_W = $clog2(NUM_DOMAINS + 1);

  logic [IDLE_W-1:0]        idle_thresh;
  logic [NUM_DOMAINS-1:0]   domain_idle;
  logic [NUM_DOMAINS-1:0]   wake_req;
  logic [NUM_DOMAINS-1:0]   pwr_gated_ack;
  logic [NUM_DOMAINS-1:0]   pwr_gate_req;
  logic [NUM_DOMAINS-1:0]   domain_ready;
  logic [2*NUM_DOMAINS-1:0] domain_state;
  logic [CNT_W-1:0]         active_count;
  logic                     all_gated;
  logic [NUM_DOMAINS-1:0]   ack_timeout_err;
  logic [6:0]               efficiency_pct;
  logic                     efficiency_valid;

  modport master (
    input  idle_thresh, domain_idle, wake_req, pwr_gated_ack,
    output pwr_gate_req, domain_ready, domain_state, active_count,
           all_gated, ack_timeout_err, efficiency_pct, efficiency_valid
  );

  modport slave (
    output idle_thresh, domain_idle, wake_req, pwr_gated_ack,
    input  pwr_gate_req, domain_ready, domain_state, active_count,
           all_gated, ack_timeout_err, efficiency_pct, efficiency_valid
  );
endinterface

// File: rtl/power_domain_manager.sv
// power_domain_manager
//   Per-domain power-gating controller. Each domain runs its own
//   ON -> GATING -> OFF -> WAKING -> ON state machine. Gating is driven by a
//   programmable idle timeout and a req/ack handshake with the power switch.
//   A handshake that takes too long is flagged in a sticky error bit.
//   The block also reports a windowed percentage of gated domain-cycles.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      power_domain_manager_if.master (inputs and status, see interface)
module power_domain_manager #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8,
  parameter int ACK_TIMEOUT = 32,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  power_domain_manager_if.master bus
);
  localparam int CNT_W  = $clog2(NUM_DOMAINS + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT);
  localparam int ACC_W  = WINDOW_LOG2 + CNT_W;
  // acc + off_count never exceeds NUM_DOMAINS * 2^WINDOW_LOG2.
  // Seven extra bits hold the *100.
  localparam int PROD_W = ACC_W + 7;
  localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [PROD_W-1:0] DIVISOR  = PROD_W'(NUM_DOMAINS) << WINDOW_LOG2;

  typedef enum logic [1:0] {
    ST_ON      = 2'b00,
    ST_GATING  = 2'b01,
    ST_OFF     = 2'b10,
    ST_WAKING  = 2'b11
  } state_t;

  state_t                 state_vec [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] err_vec;
  logic [IDLE_W-1:0]      thresh_m1;
  logic                   thresh_zero;

  assign thresh_m1   = bus.idle_thresh - IDLE_W'(1);
  assign thresh_zero = (bus.idle_thresh == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      state_t            state_reg, state_next;
      logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
      logic [ACK_W-1:0]  ack_cnt_reg, ack_cnt_next;
      logic              err_reg, err_next;
      logic              idle_i, wake_i, ack_i;

      assign idle_i = bus.domain_idle[gi];
      assign wake_i = bus.wake_req[gi];
      assign ack_i  = bus.pwr_gated_ack[gi];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state_reg    <= ST_ON;
          idle_cnt_reg <= '0;
          ack_cnt_reg  <= '0;
          err_reg      <= 1'b0;
        end else begin
          state_reg    <= state_next;
          idle_cnt_reg <= idle_cnt_next;
          ack_cnt_reg  <= ack_cnt_next;
          err_reg      <= err_next;
        end
      end

      // The ack counter counts cycles spent in the current handshake state.
      // It is zero on entry to GATING and to WAKING.
      always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        ack_cnt_next  = ack_cnt_reg;
        err_next      = err_reg;
        case (state_reg)
          ST_ON: begin
            ack_cnt_next = '0;
            if (wake_i || !idle_i) begin
              idle_cnt_next = '0;
            end else if (!thresh_zero && idle_cnt_reg == thresh_m1) begin
              state_next    = ST_GATING;
              idle_cnt_next = '0;
            end else if (idle_cnt_reg != '1) begin
              idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
            end
          end
          ST_GATING: begin
            // A wake request beats a simultaneous ack.
            if (wake_i) begin
              state_next   = ST_WAKING;
              ack_cnt_next = '0;
            end else if (ack_i) begin
              state_next   = ST_OFF;
              ack_cnt_next = '0;
            end else if (ack_cnt_reg == ACK_LAST) begin
              err_next     = 1'b1;
              state_next   = ST_WAKING;
              ack_cnt_next = '0;
            end else begin
              ack_cnt_next = ack_cnt_reg + ACK_W'(1);
            end
          end
          ST_OFF: begin
            ack_cnt_next = '0;
            if (wake_i) begin
              state_next = ST_WAKING;
            end
          end
          ST_WAKING: begin
            if (!ack_i) begin
              state_next    = ST_ON;
              idle_cnt_next = '0;
              ack_cnt_next  = '0;
            end else if (ack_cnt_reg == ACK_LAST) begin
              // The counter holds here, so the flag is raised once.
              // The state keeps waiting for the switch.
              err_next = 1'b1;
            end else begin
              ack_cnt_next = ack_cnt_reg + ACK_W'(1);
            end
          end
          default: state_next = ST_ON;
        endcase
      end

      assign state_vec[gi] = state_reg;
      assign err_vec[gi]   = err_reg;
    end
  endgenerate

  // Status decode uses the registered state only.
  logic [NUM_DOMAINS-1:0]   gate_req;
  logic [NUM_DOMAINS-1:0]   ready;
  logic [2*NUM_DOMAINS-1:0] dstate;
  logic [CNT_W-1:0]         on_count;
  logic [CNT_W-1:0]         off_count;

  always_comb begin
    gate_req  = '0;
    ready     = '0;
    dstate    = '0;
    on_count  = '0;
    off_count = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      dstate[2*i +: 2] = state_vec[i];
      gate_req[i]      = (state_vec[i] == ST_GATING) || (state_vec[i] == ST_OFF);
      ready[i]         = (state_vec[i] == ST_ON);
      if (state_vec[i] == ST_ON)  on_count  = on_count + CNT_W'(1);
      if (state_vec[i] == ST_OFF) off_count = off_count + CNT_W'(1);
    end
  end

  // Efficiency window
  logic [WINDOW_LOG2-1:0] win_cnt_reg;
  logic [ACC_W-1:0]       acc_reg;
  logic [6:0]             pct_reg;
  logic                   pct_valid_reg;
  logic [ACC_W-1:0]       acc_sum;
  logic [PROD_W-1:0]      prod;
  logic [PROD_W-1:0]      quot;

  assign acc_sum = acc_reg + ACC_W'(off_count);
  assign prod    = PROD_W'(acc_sum) * PROD_W'(100);
  assign quot    = prod / DIVISOR;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt_reg   <= '0;
      acc_reg       <= '0;
      pct_reg       <= '0;
      pct_valid_reg <= 1'b0;
    end else begin
      win_cnt_reg <= win_cnt_reg + WINDOW_LOG2'(1);
      if (win_cnt_reg == '1) begin
        pct_reg       <= quot[6:0];
        pct_valid_reg <= 1'b1;
        acc_reg       <= '0;
      end else begin
        pct_valid_reg <= 1'b0;
        acc_reg       <= acc_sum;
      end
    end
  end

  assign bus.pwr_gate_req     = gate_req;
  assign bus.domain_ready     = ready;
  assign bus.domain_state     = dstate;
  assign bus.active_count     = on_count;
  assign bus.all_gated        = (off_count == CNT_W'(NUM_DOMAINS));
  assign bus.ack_timeout_err  = err_vec;
  assign bus.efficiency_pct   = pct_reg;
  assign bus.efficiency_valid = pct_valid_reg;
endmodule

// File: tb/tb_power_domain_manager.sv
// tb_power_domain_manager
//   Drives randomized idle and wake traffic and models the power switch.
//   A behavioural model predicts the outputs after every clock edge. The
//   predictions go into queues, and a monitor compares them against the DUT.
module tb_power_domain_manager;
  localparam int N           = 4;
  localparam int IDLE_W      = 8;
  localparam int ACK_TIMEOUT = 32;
  localparam int WINDOW_LOG2 = 8;
  localparam int WIN         = 1 << WINDOW_LOG2;
  localparam int S_ON = 0, S_GATING = 1, S_OFF = 2, S_WAKING = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  power_domain_manager_if #(.NUM_DOMAINS(N), .IDLE_W(IDLE_W)) bus();

  power_domain_manager #(
    .NUM_DOMAINS(N), .IDLE_W(IDLE_W),
    .ACK_TIMEOUT(ACK_TIMEOUT), .WINDOW_LOG2(WINDOW_LOG2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [2*N-1:0] st;
    logic [N-1:0]   err;
    logic [N-1:0]   ready;
    logic [N-1:0]   gate;
    logic [2:0]     act;
    logic           allg;
    logic           valid;
  } exp_t;

  exp_t exp_q[$];
  int   pct_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one prediction per clock edge, plus one percentage per valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("domain_state",     32'(bus.domain_state),     32'(e.st));
        check("ack_timeout_err",  32'(bus.ack_timeout_err),  32'(e.err));
        check("pwr_gate_req",     32'(bus.pwr_gate_req),     32'(e.gate));
        check("domain_ready",     32'(bus.domain_ready),     32'(e.ready));
        check("active_count",     32'(bus.active_count),     32'(e.act));
        check("all_gated",        32'(bus.all_gated),        32'(e.allg));
        check("efficiency_valid", 32'(bus.efficiency_valid), 32'(e.valid));
      end
      if (bus.efficiency_valid === 1'b1) begin
        if (pct_q.size() == 0) check("efficiency_queue_depth", 32'(pct_q.size()), 32'd1);
        else check("efficiency_pct", 32'(bus.efficiency_pct), 32'(pct_q.pop_front()));
      end
    end
  end

  // Stimulus state
  logic [N-1:0] idle_v = '0, wake_v = '0, ack_v = '0;
  int thresh = 0;
  int sw_cnt[N], sw_delay[N];
  bit sw_dead = 0, sw_slow = 0;
  int pat_cnt = 0;

  // Reference model state
  int m_st[N], m_run[N], m_hs[N];
  bit m_err[N];
  int m_cyc = 0, m_sum = 0;

  task automatic model_step(input bit rst);
    exp_t e;
    int off_now, act, offn;
    e = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = S_ON; m_run[i] = 0; m_hs[i] = 0; m_err[i] = 0;
      end
      m_cyc = 0; m_sum = 0;
    end else begin
      off_now = 0;
      for (int i = 0; i < N; i++) if (m_st[i] == S_OFF) off_now++;
      if (m_cyc % WIN == WIN - 1) begin
        pct_q.push_back(((m_sum + off_now) * 100) / (N * WIN));
        e.valid = 1'b1;
        m_sum = 0;
      end else begin
        m_sum += off_now;
      end
      m_cyc++;
      for (int i = 0; i < N; i++) begin
        case (m_st[i])
          S_ON: begin
            if (wake_v[i] || !idle_v[i]) m_run[i] = 0;
            else begin
              m_run[i]++;
              if (thresh != 0 && m_run[i] >= thresh) begin
                m_st[i] = S_GATING; m_hs[i] = 0;
              end
            end
          end
          S_GATING: begin
            m_hs[i]++;
            if (wake_v[i]) begin m_st[i] = S_WAKING; m_hs[i] = 0; end
            else if (ack_v[i]) m_st[i] = S_OFF;
            else if (m_hs[i] >= ACK_TIMEOUT) begin
              m_err[i] = 1; m_st[i] = S_WAKING; m_hs[i] = 0;
            end
          end
          S_OFF: begin
            if (wake_v[i]) begin m_st[i] = S_WAKING; m_hs[i] = 0; end
          end
          default: begin
            m_hs[i]++;
            if (!ack_v[i]) begin m_st[i] = S_ON; m_run[i] = 0; end
            else if (m_hs[i] >= ACK_TIMEOUT) m_err[i] = 1;
          end
        endcase
      end
    end
    act = 0; offn = 0;
    for (int i = 0; i < N; i++) begin
      e.st[2*i +: 2] = 2'(m_st[i]);
      e.err[i]   = m_err[i];
      e.ready[i] = (m_st[i] == S_ON);
      e.gate[i]  = (m_st[i] == S_GATING) || (m_st[i] == S_OFF);
      if (m_st[i] == S_ON)  act++;
      if (m_st[i] == S_OFF) offn++;
    end
    e.act  = 3'(act);
    e.allg = (offn == N);
    exp_q.push_back(e);
  endtask

  // One clock: the switch reacts, new inputs are applied and the
  // prediction for the coming edge is queued.
  task automatic do_cycle(input bit rst, input int mode, input int idle_pct,
                          input int wake_pct, input logic [N-1:0] idle_mask);
    for (int i = 0; i < N; i++) begin
      if (bus.pwr_gate_req[i] !== ack_v[i]) begin
        if (sw_cnt[i] == 0)
          sw_delay[i] = bus.pwr_gate_req[i] ? (sw_dead ? 1000000 : int'($urandom_range(1, 4)))
                                            : (sw_slow ? 40 : int'($urandom_range(1, 4)));
        sw_cnt[i]++;
        if (sw_cnt[i] >= sw_delay[i]) begin
          ack_v[i]  = bus.pwr_gate_req[i];
          sw_cnt[i] = 0;
        end
      end else begin
        sw_cnt[i] = 0;
      end
      if (mode == 1) idle_v[i] = (pat_cnt % 4 != 3);
      else idle_v[i] = idle_mask[i] && ($urandom_range(0, 99) < idle_pct);
      wake_v[i] = ($urandom_range(0, 99) < wake_pct);
    end
    pat_cnt++;
    reset_n           = !rst;
    bus.idle_thresh   = IDLE_W'(thresh);
    bus.domain_idle   = idle_v;
    bus.wake_req      = wake_v;
    bus.pwr_gated_ack = ack_v;
    model_step(rst);
    @(posedge clk);
    #2;
  endtask

  task automatic run_phase(input int cycles, input int th, input int mode,
                           input int idle_pct, input int wake_pct,
                           input logic [N-1:0] idle_mask, input bit dead,
                           input bit slow, input int rst_at);
    thresh = th; sw_dead = dead; sw_slow = slow; pat_cnt = 0;
    do_cycle(1'b1, mode, idle_pct, wake_pct, idle_mask);
    do_cycle(1'b1, mode, idle_pct, wake_pct, idle_mask);
    for (int c = 0; c < cycles; c++)
      do_cycle((c == rst_at) || ($urandom_range(0, 499) == 0),
               mode, idle_pct, wake_pct, idle_mask);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin sw_cnt[i] = 0; sw_delay[i] = 1; end
    bus.idle_thresh = '0; bus.domain_idle = '0; bus.wake_req = '0; bus.pwr_gated_ack = '0;
    // idle traffic with occasional wakes
    run_phase(800, 3, 0, 90, 3, 4'b1111, 0, 0, -1);
    // gating disabled
    run_phase(300, 0, 0, 100, 0, 4'b1111, 0, 0, -1);
    // everything gated for whole windows
    run_phase(700, 1, 0, 100, 0, 4'b1111, 0, 0, -1);
    // half of the domains gated
    run_phase(600, 1, 0, 100, 0, 4'b0011, 0, 0, -1);
    // switch never turns off: gating timeouts, reset mid-GATING
    run_phase(250, 2, 0, 100, 1, 4'b1111, 1, 0, 10);
    // switch slow to turn back on: waking timeouts
    run_phase(400, 2, 0, 95, 5, 4'b1111, 0, 1, -1);
    // idle broken every fourth cycle never reaches a threshold of 4
    run_phase(200, 4, 1, 0, 0, 4'b1111, 0, 0, -1);
    @(negedge clk);
    #1;
    check("pending_predictions", 32'(exp_q.size()), 32'd0);
    check("pending_efficiency",  32'(pct_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
